ptmch_trg_sched: RTL and testbench

PTMCH_TRG_SCHED -- requirements
Module: ptmch_trg_sched

---
 rtl/ptmch_trg_sched.sv | 164 ++++++++++++++++
 tb/tb_ptmch_trg_sched.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ptmch_trg_sched.sv
// ptmch_trg_sched
//   Shares one trigger pulse output between three request sources:
//   program execute (0), read status (1) and block erase (2).
//   Rising edges on TRG_REQ are latched as pending requests.
//   An arbiter grants one pending source at a time. It is round-robin
//   when P_RR=1 and fixed priority (source 0 highest) when P_RR=0.
//   Each grant produces a pulse of PLS_WIDTH+1 cycles. The pulse is
//   followed by HOLDOFF idle cycles.
//
// Parameters
//   P_CNT_W   width of PLS_WIDTH, HOLDOFF and the timing counter
//   P_RR      1 = round-robin arbitration, 0 = fixed priority
//
// Ports
//   CLK200M   clock; every output is registered on its rising edge
//   RESET     asynchronous, active-high reset
//   TRG_REQ   per-source trigger request (level; edges are detected)
//   ENABLE    grant enable; while low, no new pulse starts
//   PLS_WIDTH pulse width minus one, sampled when a pulse starts
//   HOLDOFF   idle cycles after a pulse, sampled when the pulse ends
//   CLR_OVF   synchronous clear of OVF
//   TRG_OUT   shared trigger pulse
//   TRG_ID    source of the active pulse, 3 when no pulse is active
//   BUSY      high during a pulse and during its holdoff
//   OVF       sticky per-source overflow (request lost)
module ptmch_trg_sched #(
    parameter int unsigned P_CNT_W = 4,
    parameter int unsigned P_RR    = 1
) (
    input  logic               CLK200M,
    input  logic               RESET,
    input  logic [2:0]         TRG_REQ,
    input  logic               ENABLE,
    input  logic [P_CNT_W-1:0] PLS_WIDTH,
    input  logic [P_CNT_W-1:0] HOLDOFF,
    input  logic               CLR_OVF,
    output logic               TRG_OUT,
    output logic [1:0]         TRG_ID,
    output logic               BUSY,
    output logic [2:0]         OVF
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [P_CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]         req_q;
    logic [2:0]         req_edge;
    logic [2:0]         pend, pend_nxt;
    logic [2:0]         grant_clr;
    logic [2:0]         ovf_nxt;
    logic [1:0]         last_grant;
    logic [1:0]         grant_id;
    logic               grant_vld;
    logic               take;
    logic [1:0]         id_nxt;
    int unsigned        idx;

    assign req_edge = TRG_REQ & ~req_q;

    // Arbiter: scan the three sources in search order and pick the
    // first one that is pending. Round-robin starts one past the last
    // grant and wraps 2->0; fixed priority always starts at source 0.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 2'd0;
        idx       = 0;
        for (int unsigned k = 0; k < 3; k++) begin
            idx = (P_RR != 0) ? (({30'd0, last_grant} + 32'd1 + k) % 32'd3) : k;
            if (!grant_vld && pend[idx[1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = idx[1:0];
            end
        end
    end

    // Next-state logic. The counter holds the remaining cycles of the
    // current phase minus one, so a phase ends when it reads zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        take      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ENABLE && grant_vld) begin
                    state_nxt = ST_PULSE;
                    cnt_nxt   = PLS_WIDTH;
                    take      = 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    if (HOLDOFF == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = HOLDOFF - P_CNT_W'(1);
                    end
                end else begin
                    cnt_nxt = cnt - P_CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - P_CNT_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Pending and overflow update. A new edge beats the grant clear,
    // and a new overflow beats CLR_OVF.
    always_comb begin
        grant_clr = take ? (3'b001 << grant_id) : 3'b000;
        pend_nxt  = (pend & ~grant_clr) | req_edge;
        ovf_nxt   = (CLR_OVF ? 3'b000 : OVF) | (req_edge & pend & ~grant_clr);
        if (take) begin
            id_nxt = grant_id;
        end else if (state_nxt == ST_PULSE) begin
            id_nxt = TRG_ID;
        end else begin
            id_nxt = 2'd3;
        end
    end

    // Outputs are registered from the next state, so a grant is visible
    // on the same edge at which the FSM enters PULSE.
    always_ff @(posedge CLK200M or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_q      <= '0;
            pend       <= '0;
            last_grant <= 2'd2;
            TRG_OUT    <= 1'b0;
            TRG_ID     <= 2'd3;
            BUSY       <= 1'b0;
            OVF        <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            req_q   <= TRG_REQ;
            pend    <= pend_nxt;
            OVF     <= ovf_nxt;
            TRG_OUT <= (state_nxt == ST_PULSE);
            TRG_ID  <= id_nxt;
            BUSY    <= (state_nxt != ST_IDLE);
            if (take) begin
                last_grant <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_ptmch_trg_sched.sv
// tb_ptmch_trg_sched
//   Drives a fixed-priority and a round-robin instance with the same
//   stimulus. Each instance is compared every cycle against a reference
//   model that tracks pulses and holdoffs as remaining-cycle counts.
module tb_ptmch_trg_sched;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req;
    logic          en;
    logic [CW-1:0] pw;
    logic [CW-1:0] ho;
    logic          clr_ovf;

    logic          trg_o  [2];
    logic [1:0]    id_o   [2];
    logic          busy_o [2];
    logic [2:0]    ovf_o  [2];

    int n_chk  = 0;
    int n_fail = 0;

    // Model state, index 0 = fixed priority, 1 = round-robin.
    int       pl   [2];
    int       hl   [2];
    int       gid  [2];
    int       lastg[2];
    bit [2:0] pend_m[2];
    bit [2:0] ovf_m [2];
    bit [2:0] reqp;

    always #5 clk = ~clk;

    ptmch_trg_sched #(.P_CNT_W(CW), .P_RR(0)) u_fp (
        .CLK200M(clk), .RESET(rst), .TRG_REQ(req), .ENABLE(en),
        .PLS_WIDTH(pw), .HOLDOFF(ho), .CLR_OVF(clr_ovf),
        .TRG_OUT(trg_o[0]), .TRG_ID(id_o[0]), .BUSY(busy_o[0]), .OVF(ovf_o[0])
    );

    ptmch_trg_sched #(.P_CNT_W(CW), .P_RR(1)) u_rr (
        .CLK200M(clk), .RESET(rst), .TRG_REQ(req), .ENABLE(en),
        .PLS_WIDTH(pw), .HOLDOFF(ho), .CLR_OVF(clr_ovf),
        .TRG_OUT(trg_o[1]), .TRG_ID(id_o[1]), .BUSY(busy_o[1]), .OVF(ovf_o[1])
    );

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            pl[m]     = 0;
            hl[m]     = 0;
            gid[m]    = 3;
            lastg[m]  = 2;
            pend_m[m] = 3'b000;
            ovf_m[m]  = 3'b000;
        end
        reqp = 3'b000;
    endtask

    // One clock of the reference model for instance m.
    // pl = pulse cycles left including the current one.
    // hl = holdoff cycles left including the current one.
    task automatic model_step(input int m, input bit [2:0] ed);
        int       g;
        int       c;
        bit [2:0] clr;
        g   = -1;
        clr = 3'b000;
        if (pl[m] == 0 && hl[m] == 0) begin
            if (en && pend_m[m] != 3'b000) begin
                for (int k = 0; k < 3; k++) begin
                    c = (m == 1) ? (lastg[m] + 1 + k) % 3 : k;
                    if (g < 0 && pend_m[m][c]) g = c;
                end
                gid[m]   = g;
                lastg[m] = g;
                pl[m]    = int'(pw) + 1;
                hl[m]    = 0;
                clr[g]   = 1'b1;
            end
        end else if (pl[m] > 0) begin
            pl[m]--;
            if (pl[m] == 0) hl[m] = int'(ho);
        end else begin
            hl[m]--;
        end
        ovf_m[m]  = (clr_ovf ? 3'b000 : ovf_m[m]) | (ed & pend_m[m] & ~clr);
        pend_m[m] = (pend_m[m] & ~clr) | ed;
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            chk(m == 0 ? "fp_trg" : "rr_trg", 8'(trg_o[m]), 8'(pl[m] > 0));
            chk(m == 0 ? "fp_id" : "rr_id", 8'(id_o[m]), 8'((pl[m] > 0) ? gid[m] : 3));
            chk(m == 0 ? "fp_busy" : "rr_busy", 8'(busy_o[m]), 8'(pl[m] > 0 || hl[m] > 0));
            chk(m == 0 ? "fp_ovf" : "rr_ovf", 8'(ovf_o[m]), 8'(ovf_m[m]));
        end
    endtask

    task automatic step();
        bit [2:0] ed;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            ed = req & ~reqp;
            model_step(0, ed);
            model_step(1, ed);
            reqp = req;
        end
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1'b1; req = 3'b000; en = 1'b1; pw = '0; ho = '0; clr_ovf = 1'b0;
        model_reset();
        #1;
        check_all();
        run(3);
        rst = 1'b0;
        run(2);

        // Held request gives exactly one 4-cycle pulse.
        pw = 4'd3; ho = 4'd0; req = 3'b001;
        run(10);
        req = 3'b000;
        run(5);

        // All three sources at once, 1-cycle pulses, holdoff of 2.
        pw = 4'd0; ho = 4'd2; req = 3'b111;
        step();
        req = 3'b000;
        run(15);

        // Edges on 100 then 001 while another pulse is active.
        pw = 4'd4; ho = 4'd0; req = 3'b010;
        step();
        req = 3'b000; step();
        req = 3'b100; step();
        req = 3'b000; step();
        req = 3'b001; step();
        req = 3'b000;
        run(25);

        // Overflow on source 1, then a clear.
        pw = 4'd6; req = 3'b001; step();
        req = 3'b000; step();
        req = 3'b010; step();
        req = 3'b000; step();
        req = 3'b010; step();
        req = 3'b000;
        run(20);
        clr_ovf = 1'b1; step();
        clr_ovf = 1'b0;
        run(3);

        // Requests held off by ENABLE, then released.
        en = 1'b0; pw = 4'd1; req = 3'b011; step();
        req = 3'b000;
        run(10);
        en = 1'b1;
        run(15);

        // Reset in the third cycle of a 16-cycle pulse.
        pw = 4'd15; ho = 4'd0; req = 3'b001; step();
        req = 3'b000;
        run(3);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_trg", 8'(trg_o[0]), 8'd0);
        chk("rst_async_id", 8'(id_o[0]), 8'd3);
        chk("rst_async_busy", 8'(busy_o[1]), 8'd0);
        chk("rst_async_id_rr", 8'(id_o[1]), 8'd3);
        model_reset();
        run(2);
        rst = 1'b0;
        run(25);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 30) req = 3'($urandom_range(0, 7));
            en      = ($urandom_range(0, 99) < 85);
            clr_ovf = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 20)
                pw = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
            if ($urandom_range(0, 99) < 20) ho = 4'($urandom_range(0, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
